// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time loadable pattern, overlap control
// and a Mealy match output. Define SEQ_DETECT_PARAM_COUNT_EN to build the saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W       = 3,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 3'b011,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic             out_q,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [PAT_W-2:0]  hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    state_t            state_q, state_d;
    logic              out_dly_q;

    logic             acc;
    logic             full;
    logic             match;
    logic [PAT_W-1:0] window;

    // A bit is only consumed when enabled and not overridden by a pattern load.
    assign acc    = en & in_valid & ~pat_load;
    assign full   = (fill_q == FILL_MAX);
    assign window = {hist_q, in};
    assign match  = acc & full & (window == pat_q);

    assign out   = match & ~reset;
    assign out_q = out_dly_q;
    assign state = state_q;

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
            fill_d  = '0;
        end else if (pat_load) begin
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end else begin
            if (acc) begin
                hist_d = window[PAT_W-2:0];
                // Non-overlapping mode consumes the matched bits, so history restarts.
                if (match && !overlap) begin
                    fill_d = '0;
                end else if (!full) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            state_d = (fill_d == FILL_MAX) ? ST_RUN : ST_FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q     <= DEFAULT_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            state_q   <= ST_IDLE;
            out_dly_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            state_q   <= state_d;
            out_dly_q <= out;
        end
    end

`ifdef SEQ_DETECT_PARAM_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && pat_load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus a randomized run against a
// queue-based model of the accepted bit stream.
module tb_seq_detect_param;

  localparam int PW = 3;
`ifdef SEQ_DETECT_PARAM_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in = 3'b000;

  logic       dout, dout_q;
  logic [1:0] state;
  logic [7:0] match_cnt;
  logic       dout2, dout_q2;
  logic [1:0] state2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  // model: accepted bits since the last history clear, oldest first
  bit         m_q[$];
  logic [2:0] m_pat = 3'b011;
  int         m_cnt = 0;
  int         m_cnt2 = 0;
  logic       m_outq = 1'b0;
  logic [1:0] m_state = 2'b00;

  logic       exp_out, exp_outq;
  logic [1:0] exp_state;
  int         exp_cnt, exp_cnt2;

  seq_detect_param #(.PAT_W(3), .DEFAULT_PAT(3'b011), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in(din),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .out(dout), .out_q(dout_q), .state(state), .match_cnt(match_cnt)
  );

  seq_detect_param #(.PAT_W(3), .DEFAULT_PAT(3'b011), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in(din),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .out(dout2), .out_q(dout_q2), .state(state2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  // drive one cycle; exp_* describe what the DUT shows before the coming edge
  task automatic drive(input logic e, input logic v, input logic b, input logic ov,
                       input logic ld, input logic [2:0] pin);
    bit acc, hit;
    @(negedge clk);
    en = e; in_valid = v; din = b; overlap = ov; pat_load = ld; pat_in = pin;
    #1;
    acc = e && v && !ld;
    hit = acc && (m_q.size() == PW - 1);
    if (hit) begin
      for (int k = 0; k < PW - 1; k++) if (m_q[k] != m_pat[PW-1-k]) hit = 1'b0;
      if (b != m_pat[0]) hit = 1'b0;
    end
    exp_out = hit; exp_outq = m_outq; exp_state = m_state;
    exp_cnt = m_cnt; exp_cnt2 = m_cnt2;
    if (!e) begin
      m_q.delete();
      m_state = 2'b00;
    end else if (ld) begin
      m_pat = pin; m_q.delete(); m_cnt = 0; m_cnt2 = 0; m_state = 2'b01;
    end else begin
      if (hit && CNT_ON) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (acc) begin
        if (hit && !ov) m_q.delete();
        else begin
          m_q.push_back(b);
          while (m_q.size() > PW - 1) void'(m_q.pop_front());
        end
      end
      m_state = (m_q.size() == PW - 1) ? 2'b10 : 2'b01;
    end
    m_outq = hit;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1; #1;
    m_q.delete(); m_pat = 3'b011; m_cnt = 0; m_cnt2 = 0; m_outq = 1'b0; m_state = 2'b00;
    checks++; if (dout_q !== 1'b0) begin errors++; $display("FAIL rst_out_q got %b exp 0", dout_q); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", state); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", match_cnt); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rst_out got %b exp 0", dout); end
    en = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; in_valid = 1'b1; din = 1'b1;
    #2;
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_out got %b exp 0", dout); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (dout_q !== 1'b0) begin errors++; $display("FAIL reset_out_q got %b exp 0", dout_q); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", match_cnt); end
    en = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] bits = 3'b011;
    logic [5:0] st = {2'b00, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, bits[2-i], 0, 0, 3'b000);
      checks++; if (dout !== (i == 2)) begin errors++; $display("FAIL basic_out%0d got %b exp %b", i, dout, (i == 2)); end
      checks++; if (state !== st[5-2*i -: 2]) begin errors++; $display("FAIL basic_state%0d got %b exp %b", i, state, st[5-2*i -: 2]); end
    end
    drive(1, 0, 0, 0, 0, 3'b000);
    checks++; if (dout_q !== 1'b1) begin errors++; $display("FAIL basic_out_q got %b exp 1", dout_q); end
    checks++; if (match_cnt !== 8'(CNT_ON ? 1 : 0)) begin errors++; $display("FAIL basic_cnt got %0d exp %0d", match_cnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_overlap();
    logic [4:0] bits = 5'b10101;
    logic [4:0] exp_ov = 5'b00101;
    logic [4:0] exp_no = 5'b00100;
    for (int pass = 0; pass < 2; pass++) begin
      drive(1, 1, 1, pass == 0, 1, 3'b101);
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL ovl_load_out got %b exp 0", dout); end
      for (int i = 0; i < 5; i++) begin
        drive(1, 1, bits[4-i], pass == 0, 0, 3'b000);
        if (pass == 0) begin
          checks++; if (dout !== exp_ov[4-i]) begin errors++; $display("FAIL ovl_on_out%0d got %b exp %b", i, dout, exp_ov[4-i]); end
        end else begin
          checks++; if (dout !== exp_no[4-i]) begin errors++; $display("FAIL ovl_off_out%0d got %b exp %b", i, dout, exp_no[4-i]); end
        end
      end
      drive(1, 0, 0, pass == 0, 0, 3'b000);
      checks++; if (match_cnt !== 8'(CNT_ON ? 2 - pass : 0)) begin errors++; $display("FAIL ovl_cnt%0d got %0d exp %0d", pass, match_cnt, CNT_ON ? 2 - pass : 0); end
      checks++; if (match_cnt2 !== 2'(CNT_ON ? 2 - pass : 0)) begin errors++; $display("FAIL ovl_cnt2_%0d got %0d exp %0d", pass, match_cnt2, CNT_ON ? 2 - pass : 0); end
    end
  endtask

  task automatic test_gaps();
    // 0, gap, 1, gap x3, 1 ; gaps carry in=1 so a dropped gate would show
    logic [6:0] v    = 7'b1010001;
    logic [6:0] bits = 7'b0111111;
    drive(1, 1, 0, 0, 1, 3'b011);
    for (int i = 0; i < 7; i++) begin
      drive(1, v[6-i], bits[6-i], 0, 0, 3'b000);
      checks++; if (dout !== (i == 6)) begin errors++; $display("FAIL gap_out%0d got %b exp %b", i, dout, (i == 6)); end
    end
  endtask

  task automatic test_load_midstream();
    drive(1, 1, 0, 0, 0, 3'b000);
    drive(1, 1, 1, 0, 0, 3'b000);
    drive(1, 1, 1, 0, 1, 3'b110);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL load_out got %b exp 0", dout); end
    drive(1, 0, 0, 0, 0, 3'b000);
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL load_cnt got %0d exp 0", match_cnt); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL load_state got %b exp 01", state); end
    drive(1, 1, 1, 0, 0, 3'b000);
    drive(1, 1, 1, 0, 0, 3'b000);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL load_pre_out got %b exp 0", dout); end
    drive(1, 1, 0, 0, 0, 3'b000);
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL load_match_out got %b exp 1", dout); end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 0, 0, 0, 3'b000);
    drive(1, 1, 1, 0, 0, 3'b000);
    apply_reset();
    drive(1, 1, 1, 0, 0, 3'b000);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rmid_single_out got %b exp 0", dout); end
    drive(1, 1, 0, 0, 0, 3'b000);
    drive(1, 1, 1, 0, 0, 3'b000);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rmid_pre_out got %b exp 0", dout); end
    drive(1, 1, 1, 0, 0, 3'b000);
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL rmid_match_out got %b exp 1", dout); end
  endtask

  task automatic test_count_sat();
    int m;
    drive(1, 1, 0, 1, 1, 3'b111);
    for (int j = 1; j <= 8; j++) begin
      drive(1, j <= 7, 1, 1, 0, 3'b000);
      m = (j > 3) ? j - 3 : 0;
      if (j <= 7) begin
        checks++; if (dout !== (j >= 3)) begin errors++; $display("FAIL sat_out%0d got %b exp %b", j, dout, (j >= 3)); end
        checks++; if (dout2 !== (j >= 3)) begin errors++; $display("FAIL sat_out2_%0d got %b exp %b", j, dout2, (j >= 3)); end
      end
      checks++; if (match_cnt2 !== 2'(CNT_ON ? (m > 3 ? 3 : m) : 0)) begin errors++; $display("FAIL sat_cnt2_%0d got %0d exp %0d", j, match_cnt2, CNT_ON ? (m > 3 ? 3 : m) : 0); end
      checks++; if (match_cnt !== 8'(CNT_ON ? m : 0)) begin errors++; $display("FAIL sat_cnt%0d got %0d exp %0d", j, match_cnt, CNT_ON ? m : 0); end
    end
  endtask

  task automatic test_random();
    logic e, v, b, ov, ld;
    logic [2:0] pin;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
      e   = ($urandom_range(0, 15) != 0);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      ov  = ((i / 40) % 2) == 0;
      ld  = ($urandom_range(0, 24) == 0);
      pin = 3'($urandom_range(0, 7));
      drive(e, v, b, ov, ld, pin);
      checks++; if (dout !== exp_out) begin errors++; $display("FAIL rnd_out@%0d got %b exp %b", i, dout, exp_out); end
      checks++; if (dout_q !== exp_outq) begin errors++; $display("FAIL rnd_out_q@%0d got %b exp %b", i, dout_q, exp_outq); end
      checks++; if (state !== exp_state) begin errors++; $display("FAIL rnd_state@%0d got %b exp %b", i, state, exp_state); end
      checks++; if (match_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", i, match_cnt, exp_cnt); end
      checks++; if (match_cnt2 !== 2'(exp_cnt2)) begin errors++; $display("FAIL rnd_cnt2@%0d got %0d exp %0d", i, match_cnt2, exp_cnt2); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gaps();
    test_load_midstream();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
